// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
//==============================================================================
// sobel_frame_ctrl : streams one frame through the RGB Sobel filter and stores
//                    the results, with pause, drain and drain watchdog. Rev 1.0
//==============================================================================
module sobel_frame_ctrl #(
    parameter int WIDTH   = 128,
    parameter int HEIGHT  = 128,
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    input  logic              flt_rcv_req,
    output logic              flt_rcv_ack,
    output logic [23:0]       flt_pixel,
    output logic              flt_snd_req,
    input  logic              flt_snd_ack,
    input  logic [23:0]       flt_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int WD_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(PIXELS);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PIXELS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic [WD_W-1:0]  r_wdog;
    logic             r_err;
    logic             r_rcv_ack;
    logic             r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [23:0]      r_wr_data;

    logic w_accept;
    logic w_issue;
    logic w_capture;
    logic w_frame_out;
    logic w_wdog_hit;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_issue     = (r_state == S_FETCH) && flt_rcv_req && !pause;
    assign w_frame_out = (r_out_cnt == FRAME_END);
    // Surplus acks beyond a full frame are dropped so out_cnt never passes FRAME_END.
    assign w_capture   = ((r_state == S_FETCH) || (r_state == S_DRAIN)) && flt_snd_ack && !w_frame_out;
    assign w_wdog_hit  = (r_wdog == WD_LIMIT);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_issue && (r_in_cnt == FRAME_LAST)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_frame_out || w_wdog_hit) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == S_FETCH) || (r_state == S_DRAIN);
        done        = (r_state == S_DONE);
        rd_en       = w_issue;
        rd_addr     = w_issue ? r_in_cnt[ADDR_W-1:0] : '0;
        flt_snd_req = ((r_state == S_FETCH) && !pause) || (r_state == S_DRAIN);
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wdog    <= '0;
            r_err     <= 1'b0;
            r_rcv_ack <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            // Ack follows the read strobe by the memory latency, whatever the state.
            r_rcv_ack <= w_issue;
            r_wr_en   <= w_capture;
            if (w_capture) begin
                r_wr_addr <= r_out_cnt[ADDR_W-1:0];
                r_wr_data <= flt_result;
            end
            if (w_accept) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_wdog    <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_issue)   r_in_cnt  <= r_in_cnt + 1'b1;
                if (w_capture) r_out_cnt <= r_out_cnt + 1'b1;
                if (r_state == S_DRAIN) begin
                    if (flt_snd_ack)      r_wdog <= '0;
                    else if (!w_wdog_hit) r_wdog <= r_wdog + 1'b1;
                    if (w_wdog_hit && !w_frame_out) r_err <= 1'b1;
                end
            end
        end
    end

    assign err         = r_err;
    assign flt_rcv_ack = r_rcv_ack;
    assign flt_pixel   = rd_data;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
//==============================================================================
// tb_sobel_frame_ctrl : scenario-table bench with a queue-based filter model.
//==============================================================================
module tb_sobel_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 4;
    localparam int TO = 8;
    localparam int N  = W * H;

    logic          clk;
    logic          xrst;
    logic          start;
    logic          pause;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data;
    logic          flt_rcv_req;
    logic          flt_rcv_ack;
    logic [23:0]   flt_pixel;
    logic          flt_snd_req;
    logic          flt_snd_ack;
    logic [23:0]   flt_result;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;

    sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .xrst(xrst), .start(start), .pause(pause),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .flt_rcv_req(flt_rcv_req), .flt_rcv_ack(flt_rcv_ack), .flt_pixel(flt_pixel),
        .flt_snd_req(flt_snd_req), .flt_snd_ack(flt_snd_ack), .flt_result(flt_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source frame buffer with one cycle of read latency.
    logic [23:0] mem [N];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct {
        int req_mode;    // 0 always ready, 1 alternate cycles, 2 random
        int pause_lo;    // pause window, cycles after start (-1 = none)
        int pause_hi;
        int rand_pause;
        int drop_last;   // filter never delivers its final result
        int restart_at;  // extra start pulse this many cycles after start (0 = none)
        int exp_writes;
        int exp_err;
    } scen_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int req_mode, pause_lo = -1, pause_hi = -1, rand_pause, drop_last;
    bit do_start, force_ack;
    logic [23:0] fq_data[$];
    int          fq_due[$];
    int flt_outs, last_ack_cyc, last_issue_cyc, last_wr_cyc, done_cyc;
    bit active, fetching, err_at_done;
    int issued, wr_cnt, ack_idx, dones, start_cyc = -1000;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {busy, done, err, rd_en, rd_addr, flt_rcv_ack, flt_snd_req,
                     wr_en, wr_addr, wr_data}, 64'd0);
    endtask

    task automatic drive_cycle();
        int rel;
        logic [23:0] d;
        rel   = cyc - start_cyc;
        start = do_start;
        do_start = 1'b0;
        case (req_mode)
            0:       flt_rcv_req = 1'b1;
            1:       flt_rcv_req = (cyc % 2 == 0);
            default: flt_rcv_req = ($urandom_range(3) != 0);
        endcase
        pause = (pause_lo >= 0 && rel >= pause_lo && rel <= pause_hi) ||
                (rand_pause != 0 && $urandom_range(4) == 0);
        flt_snd_ack = 1'b0;
        flt_result  = 24'd0;
        if (force_ack) begin
            flt_snd_ack = 1'b1;
            flt_result  = 24'($urandom);
            force_ack   = 1'b0;
        end else if (fq_due.size() > 0 && fq_due[0] <= cyc) begin
            d = fq_data.pop_front();
            void'(fq_due.pop_front());
            flt_outs++;
            if (!(drop_last != 0 && flt_outs == N)) begin
                flt_snd_ack  = 1'b1;
                flt_result   = d;
                last_ack_cyc = cyc;
            end
        end
    endtask

    task automatic sample_cycle();
        bit active_pre;
        bit exp_rd, exp_sreq;
        active_pre = active;
        exp_rd   = fetching && flt_rcv_req && !pause;
        exp_sreq = fetching ? !pause : (active_pre && !done);
        if (active_pre) begin
            if (done) begin
                check("busy_at_done", busy, 0);
                done_cyc    = cyc;
                err_at_done = err;
                dones++;
                active = 1'b0;
            end else begin
                check("busy", busy, 1);
            end
            if (cyc == start_cyc + 1) check("err_cleared", err, 0);
        end else begin
            check("busy_idle", busy, 0);
            check("done_idle", done, 0);
            check("wr_idle", wr_en, 0);
            check("ack_idle", flt_rcv_ack, 0);
        end
        check("rd_en", rd_en, exp_rd);
        check("flt_snd_req", flt_snd_req, exp_sreq);
        if (rd_en) begin
            check("rd_addr", rd_addr, issued);
            issued++;
            last_issue_cyc = cyc;
            if (issued == N) fetching = 1'b0;
        end
        if (wr_en) begin
            check("wr_addr", wr_addr, wr_cnt);
            check("wr_data", wr_data, (wr_cnt < N) ? (mem[wr_cnt] ^ 24'hFFFFFF) : 24'd0);
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (flt_rcv_ack) begin
            check("flt_pixel", flt_pixel, mem[ack_idx % N]);
            // Filter model: inverted pixel, result three cycles after it is handed over.
            fq_data.push_back(flt_pixel ^ 24'hFFFFFF);
            fq_due.push_back(cyc + 3);
            ack_idx++;
        end
        if (start && !active_pre) begin
            active = 1'b1; fetching = 1'b1;
            issued = 0; wr_cnt = 0; ack_idx = 0; flt_outs = 0; dones = 0;
            start_cyc = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_cycle();
        @(negedge clk);
        sample_cycle();
    endtask

    task automatic run_scen(input scen_t s);
        int n;
        int ref_cyc;
        req_mode = s.req_mode; pause_lo = s.pause_lo; pause_hi = s.pause_hi;
        rand_pause = s.rand_pause; drop_last = s.drop_last;
        force_ack = 1'b1;     // stray filter result while idle must be ignored
        step();
        step();
        do_start = 1'b1;
        step();
        n = 0;
        while (active && n < 400) begin
            if (s.restart_at > 0 && cyc + 1 - start_cyc == s.restart_at) do_start = 1'b1;
            step();
            n++;
        end
        check("done_seen", active, 0);
        active = 1'b0; fetching = 1'b0;
        check("issued", issued, N);
        check("writes", wr_cnt, s.exp_writes);
        check("err_at_done", err_at_done, s.exp_err);
        if (s.exp_err != 0) begin
            // Watchdog counts silent drain cycles from the later of the last
            // result and drain entry; TO of them, then one cycle to reach DONE.
            ref_cyc = (last_ack_cyc > last_issue_cyc) ? last_ack_cyc + 1 : last_issue_cyc + 1;
            check("wdog_latency", done_cyc, ref_cyc + TO + 1);
        end else begin
            check("done_latency", done_cyc, last_wr_cyc + 1);
        end
        repeat (6) step();
        check("err_sticky", err, s.exp_err);
        check("done_count", dones, 1);
        pause_lo = -1; pause_hi = -1; rand_pause = 0; drop_last = 0;
    endtask

    scen_t tbl[7];
    scen_t normal;

    initial begin
        xrst = 1'b0; start = 1'b0; pause = 1'b0;
        flt_rcv_req = 1'b0; flt_snd_ack = 1'b0; flt_result = 24'd0;
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);

        //         req pl  ph  rp drop rst wr err
        tbl[0] = '{0, -1, -1, 0, 0,   0,  16, 0};
        tbl[1] = '{0,  5,  9, 0, 0,   0,  16, 0};
        tbl[2] = '{1, -1, -1, 0, 0,   0,  16, 0};
        tbl[3] = '{0, -1, -1, 0, 1,   0,  15, 1};
        tbl[4] = '{0, -1, -1, 0, 0,   6,  16, 0};
        tbl[5] = '{2, -1, -1, 1, 0,   0,  16, 0};
        tbl[6] = '{2, -1, -1, 1, 1,   0,  15, 1};
        normal = tbl[0];

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        xrst = 1'b1;

        for (int i = 0; i < 7; i++) run_scen(tbl[i]);

        // Asynchronous reset in the middle of a frame.
        req_mode = 0;
        do_start = 1'b1;
        step();
        for (int n = 0; n < 100 && issued < 8; n++) step();
        check("issued_before_reset", issued, 8);
        @(posedge clk);
        #2;
        xrst = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        active = 1'b0; fetching = 1'b0;
        step();
        step();
        xrst = 1'b1;
        repeat (10) step();
        check("err_after_reset", err, 0);
        run_scen(normal);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
